serial_rx_datapath: RTL and testbench

- Receive side of the team's serial bit link: rebuilds parallel words from the LSB-first bit stream driven by the shift-register transmitter (one bit per cycle, qualified by an output-enable strobe).
- Holds each finished word in an output register behind a valid/ready handshake.
- Reports aborted frames and overruns.
- Sits between the link pins and the consumer logic, in the same clock domain as the transmitter.

---
 rtl/serial_link_pkg.sv | 15 +
 rtl/serial_rx_ctrl.sv | 69 ++++++
 rtl/serial_rx_datapath.sv | 103 ++++++++++
 tb/tb_serial_rx_datapath.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial bit link.
// Used by both the transmitter and the receiver.
package serial_link_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

  localparam int WIDTH_DEF = 8;

  // Bit 0 of a word travels first on the wire.
  localparam bit LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_rx_ctrl.sv
// Receive framing FSM for the serial link.
// Turns the bit strobe into shift/count/complete/abort controls.
module serial_rx_ctrl
  import serial_link_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sin_en_i,
  input  logic [CW-1:0] count_i,
  output logic          shift_en_o,
  output logic          cnt_clr_o,
  output logic          cnt_inc_o,
  output logic          complete_o,
  output logic          abort_o,
  output logic          busy_o
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  rx_state_e state_q, state_d;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and control strobes.
  always_comb begin
    state_d    = state_q;
    shift_en_o = 1'b0;
    cnt_clr_o  = 1'b0;
    cnt_inc_o  = 1'b0;
    complete_o = 1'b0;
    abort_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sin_en_i) begin
          shift_en_o = 1'b1;
          cnt_inc_o  = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (!sin_en_i) begin
          abort_o   = 1'b1;
          cnt_clr_o = 1'b1;
          state_d   = IDLE;
        end else if (count_i == LAST) begin
          shift_en_o = 1'b1;
          complete_o = 1'b1;
          cnt_clr_o  = 1'b1;
          state_d    = IDLE;
        end else begin
          shift_en_o = 1'b1;
          cnt_inc_o  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A frame is in flight exactly while the FSM sits in SHIFT.
  assign busy_o = (state_q == SHIFT);

endmodule

// File: rtl/serial_rx_datapath.sv
// Serial link receiver: rebuilds LSB-first words and
// presents them behind a valid/ready output register.
module serial_rx_datapath
  import serial_link_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_ovr
);

  logic             shift_en, cnt_clr, cnt_inc;
  logic             complete, abort;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] word;

  serial_rx_ctrl #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .sin_en_i   (sin_en),
    .count_i    (cnt_q),
    .shift_en_o (shift_en),
    .cnt_clr_o  (cnt_clr),
    .cnt_inc_o  (cnt_inc),
    .complete_o (complete),
    .abort_o    (abort),
    .busy_o     (busy)
  );

  // New bits enter at the top so the first bit lands in bit 0.
  assign word = {sin, sr_q[WIDTH-1:1]};

  // Shift register and bit counter next state.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (abort)         sr_d = '0;
    else if (shift_en) sr_d = word;
    if (cnt_clr)       cnt_d = '0;
    else if (cnt_inc)  cnt_d = cnt_q + 1'b1;
  end

  // Output register, handshake and overrun next state.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clr_ovr) ovr_d = 1'b0;
    if (complete) begin
      if (!valid_q || out_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Datapath state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= abort;
      ovr_q   <= ovr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_serial_rx_datapath.sv
// Self-checking bench for serial_rx_datapath.
// Delivered words are checked against a queue.
module tb_serial_rx_datapath;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         sin;
  logic         sin_en;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         frame_err;
  logic         overrun;
  logic         clr_ovr;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] sb[$];

  serial_rx_datapath #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_en    (sin_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge, then step past the next rise.
  task automatic tick;
    logic [W-1:0] e;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_data", 32'(out_data), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      sin    = w[i];
      sin_en = 1'b1;
      tick();
      chk("busy_part", 32'(busy), 32'd1);
    end
  endtask

  // Full frame; rdy_last raises out_ready with the final bit.
  task automatic send_frame(input logic [W-1:0] w,
                            input bit deliver,
                            input bit rdy_last);
    if (deliver) sb.push_back(w);
    for (int i = 0; i < W; i++) begin
      sin    = w[i];
      sin_en = 1'b1;
      if (rdy_last && i == W - 1) out_ready = 1'b1;
      tick();
      chk("busy_frm", 32'(busy), 32'(i < W - 1));
      chk("ferr_frm", 32'(frame_err), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    sin_en = 1'b0;
    sin    = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    sin       = 1'b0;
    sin_en    = 1'b0;
    out_ready = 1'b1;
    clr_ovr   = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    idle(2);

    // 1: single frame 0xA5
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'hA5);
    idle(1);
    chk("t1_drop", 32'(out_valid), 32'd0);
    chk("t1_hold", 32'(out_data), 32'hA5);
    idle(2);

    // 2: abort after 3 bits, then 0x5A
    send_bits(8'h07, 3);
    idle(1);
    chk("t2_ferr", 32'(frame_err), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_valid", 32'(out_valid), 32'd0);
    idle(1);
    chk("t2_ferr_pulse", 32'(frame_err), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0);
    chk("t2_data", 32'(out_data), 32'h5A);
    idle(3);

    // 3: back-to-back frames
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    chk("t3_data", 32'(out_data), 32'hC3);
    idle(3);

    // 4: overrun with consumer stalled
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    idle(1);
    chk("t4_data", 32'(out_data), 32'h11);
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_ovr", 32'(overrun), 32'd1);
    idle(2);
    chk("t4_ovr_sticky", 32'(overrun), 32'd1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("t4_ovr_clr", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("t4_consumed", 32'(out_valid), 32'd0);
    idle(2);

    // 5: consume and refill in the same cycle
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    idle(2);
    send_frame(8'h77, 1'b1, 1'b1);
    chk("t5_valid", 32'(out_valid), 32'd1);
    chk("t5_data", 32'(out_data), 32'h77);
    chk("t5_ovr", 32'(overrun), 32'd0);
    idle(3);

    // 6: reset mid-frame with a stale word and overrun
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    chk("t6_pre_ovr", 32'(overrun), 32'd1);
    send_bits(8'h0F, 4);
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_data", 32'(out_data), 32'd0);
    chk("t6_ovr", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    send_frame(8'hFF, 1'b1, 1'b0);
    chk("t6_ff", 32'(out_data), 32'hFF);
    idle(4);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
